// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write, issue and status signals of the
// multi-port register file, with pipeline (master) and regfile (slave) views.
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) ();
    localparam int AW = $clog2(DEPTH);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic [DEPTH-1:0]    busy_vec;
    logic                err_collide;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_vec, err_collide
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, busy_vec, err_collide
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read / NWR-write register file with pending-write scoreboard.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0]     mem [DEPTH];
    logic [DEPTH-1:0]    busy;
    logic [DEPTH-1:0]    busy_nxt;
    logic                err_q;
    logic                collide;
    logic [NWR-1:0]      wr_ok;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [AW-1:0]       ra;
    logic [XLEN-1:0]     rdata;

    // Writes to x0 are dropped when it is hardwired to zero
    always_comb begin
        wr_ok = '0;
        for (int w = 0; w < NWR; w++) begin
            wr_ok[w] = bus.wr_en[w] &&
                !(ZERO_REG != 0 && bus.wr_addr[w*AW +: AW] == '0);
        end
    end

    generate
        if (NWR > 1) begin : g_coll
            assign collide = wr_ok[0] && wr_ok[1] &&
                (bus.wr_addr[0 +: AW] == bus.wr_addr[AW +: AW]);
        end else begin : g_nocoll
            assign collide = 1'b0;
        end
    endgenerate

    // Set beats clear: a fresh issue is younger than any writeback
    always_comb begin
        busy_nxt = busy;
        for (int r = 0; r < DEPTH; r++) begin
            for (int w = 0; w < NWR; w++) begin
                if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == AW'(r))
                    busy_nxt[r] = 1'b0;
            end
            if (bus.iss_en && bus.iss_addr == AW'(r))
                busy_nxt[r] = 1'b1;
        end
        if (ZERO_REG != 0)
            busy_nxt[0] = 1'b0;
    end

    // Later port index is written last, so port 1 wins a collision
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++)
                mem[r] <= '0;
            busy  <= '0;
            err_q <= 1'b0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_ok[w])
                    mem[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*XLEN +: XLEN];
            end
            busy <= busy_nxt;
            if (collide)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        rdata   = '0;
        for (int p = 0; p < NRD; p++) begin
            ra    = bus.rd_addr[p*AW +: AW];
            rdata = mem[ra];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NWR; w++) begin
                if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == ra)
                    rdata = bus.wr_data[w*XLEN +: XLEN];
            end
`endif
            if (ZERO_REG != 0 && ra == '0)
                rdata = '0;
            rd_data[p*XLEN +: XLEN] = rdata;
            rd_busy[p]              = busy[ra];
        end
    end

    assign bus.rd_data     = rd_data;
    assign bus.rd_busy     = rd_busy;
    assign bus.busy_vec    = busy;
    assign bus.err_collide = err_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks on the default regfile plus a
// randomised sweep of a DEPTH=16, NRD=3, NWR=1, XLEN=64 instance.
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [63:0] ref_mem [16];
    logic [63:0] exp_d;
    logic [63:0] wd;
    logic        we;
    logic [3:0]  wa;
    logic [3:0]  ra;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .DEPTH(32), .NRD(2), .NWR(2)) bus_a ();
    regfile_mp_if #(.XLEN(64), .DEPTH(16), .NRD(3), .NWR(1)) bus_b ();

    regfile_mp #(
        .XLEN(32), .DEPTH(32), .NRD(2), .NWR(2), .ZERO_REG(1)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    regfile_mp #(
        .XLEN(64), .DEPTH(16), .NRD(3), .NWR(1), .ZERO_REG(1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_a();
        bus_a.wr_en    = '0;
        bus_a.wr_addr  = '0;
        bus_a.wr_data  = '0;
        bus_a.iss_en   = 1'b0;
        bus_a.iss_addr = '0;
    endtask

    task automatic wr_a(input int w, input logic [4:0] a,
                        input logic [31:0] d);
        bus_a.wr_en[w]           = 1'b1;
        bus_a.wr_addr[w*5 +: 5]  = a;
        bus_a.wr_data[w*32 +: 32] = d;
    endtask

    task automatic iss_a(input logic [4:0] a);
        bus_a.iss_en   = 1'b1;
        bus_a.iss_addr = a;
    endtask

    initial begin
        idle_a();
        bus_a.rd_addr  = '0;
        bus_b.rd_addr  = '0;
        bus_b.wr_en    = '0;
        bus_b.wr_addr  = '0;
        bus_b.wr_data  = '0;
        bus_b.iss_en   = 1'b0;
        bus_b.iss_addr = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;

        // Reset state
        repeat (2) step();
        bus_a.rd_addr = {5'd5, 5'd3};
        #1;
        check("rst_rd0", 64'(bus_a.rd_data[31:0]), 64'h0);
        check("rst_rd1", 64'(bus_a.rd_data[63:32]), 64'h0);
        check("rst_busy", 64'(bus_a.busy_vec), 64'h0);
        check("rst_err", 64'(bus_a.err_collide), 64'h0);
        rst = 1'b1;
        step();

        // x0: write on both ports (no collision) and issue
        wr_a(0, 5'd0, 32'h12345678);
        wr_a(1, 5'd0, 32'h87654321);
        iss_a(5'd0);
        bus_a.rd_addr = {5'd0, 5'd0};
        step();
        idle_a();
        #1;
        check("x0_rd", 64'(bus_a.rd_data[31:0]), 64'h0);
        check("x0_busy", 64'(bus_a.busy_vec), 64'h0);
        check("x0_err", 64'(bus_a.err_collide), 64'h0);
        step();
        check("x0_rd_next", 64'(bus_a.rd_data[63:32]), 64'h0);
        check("x0_busy_next", 64'(bus_a.busy_vec), 64'h0);

        // Bypass on x7
        wr_a(0, 5'd7, 32'h11111111);
        step();
        idle_a();
        wr_a(0, 5'd7, 32'hA5A5A5A5);
        bus_a.rd_addr = {5'd7, 5'd0};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_same", 64'(bus_a.rd_data[63:32]), 64'hA5A5A5A5);
`else
        check("byp_same", 64'(bus_a.rd_data[63:32]), 64'h11111111);
`endif
        step();
        idle_a();
        #1;
        check("byp_next", 64'(bus_a.rd_data[63:32]), 64'hA5A5A5A5);

        // Collision on x9
        wr_a(0, 5'd9, 32'h1);
        wr_a(1, 5'd9, 32'h2);
        step();
        idle_a();
        bus_a.rd_addr = {5'd0, 5'd9};
        #1;
        check("coll_data", 64'(bus_a.rd_data[31:0]), 64'h2);
        check("coll_err", 64'(bus_a.err_collide), 64'h1);
        step();
        check("coll_sticky", 64'(bus_a.err_collide), 64'h1);

        // Scoreboard ordering on x3
        iss_a(5'd3);
        step();
        idle_a();
        bus_a.rd_addr = {5'd0, 5'd3};
        #1;
        check("sb_issue", 64'(bus_a.busy_vec), 64'h8);
        check("sb_rdbusy", 64'(bus_a.rd_busy), 64'h1);
        iss_a(5'd3);
        wr_a(0, 5'd3, 32'h33);
        step();
        idle_a();
        #1;
        check("sb_set_wins", 64'(bus_a.busy_vec), 64'h8);
        wr_a(1, 5'd3, 32'h34);
        #1;
        check("sb_no_byp", 64'(bus_a.rd_busy), 64'h1);
        step();
        idle_a();
        #1;
        check("sb_clear", 64'(bus_a.busy_vec), 64'h0);
        check("sb_data", 64'(bus_a.rd_data[31:0]), 64'h34);

        // Two-port clear of x4 and x6
        iss_a(5'd4);
        step();
        idle_a();
        iss_a(5'd6);
        step();
        idle_a();
        #1;
        check("sb_two", 64'(bus_a.busy_vec), 64'h50);
        wr_a(0, 5'd4, 32'h4);
        wr_a(1, 5'd6, 32'h6);
        step();
        idle_a();
        #1;
        check("sb_two_clr", 64'(bus_a.busy_vec), 64'h0);

        // Asynchronous reset mid-cycle
        wr_a(0, 5'd5, 32'hDEADBEEF);
        iss_a(5'd5);
        step();
        idle_a();
        bus_a.rd_addr = {5'd9, 5'd5};
        #1;
        check("pre_rst_rd", 64'(bus_a.rd_data[31:0]), 64'hDEADBEEF);
        check("pre_rst_busy", 64'(bus_a.busy_vec), 64'h20);
        #1;
        rst = 1'b0;
        #1;
        check("arst_rd", 64'(bus_a.rd_data[31:0]), 64'h0);
        check("arst_rd9", 64'(bus_a.rd_data[63:32]), 64'h0);
        check("arst_busy", 64'(bus_a.busy_vec), 64'h0);
        check("arst_err", 64'(bus_a.err_collide), 64'h0);
        #1;
        rst = 1'b1;
        wr_a(0, 5'd5, 32'hCAFEF00D);
        step();
        idle_a();
        #1;
        check("post_rst_wr", 64'(bus_a.rd_data[31:0]), 64'hCAFEF00D);

        // Parameter sweep on the 64-bit, 3-read, 1-write instance
        for (int c = 0; c < 10000; c++) begin
            we = 1'($urandom_range(0, 1));
            wa = 4'($urandom_range(0, 15));
            wd = {$urandom, $urandom};
            bus_b.wr_en   = we;
            bus_b.wr_addr = wa;
            bus_b.wr_data = wd;
            bus_b.rd_addr = 12'($urandom);
            #1;
            for (int p = 0; p < 3; p++) begin
                ra    = bus_b.rd_addr[p*4 +: 4];
                exp_d = ref_mem[ra];
`ifdef REGFILE_BYPASS_EN
                if (we && wa == ra) exp_d = wd;
`endif
                if (ra == 4'd0) exp_d = '0;
                check($sformatf("sweep_c%0d_p%0d", c, p),
                      bus_b.rd_data[p*64 +: 64], exp_d);
            end
            step();
            if (we && wa != 4'd0) ref_mem[wa] = wd;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
